// File: rtl/spi_valdet_ctrl_pkg.sv
// Shared types for the SPI frame-validity detector.
// Channel FSM codes and the per-channel filter status bundle.
package spi_valdet_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_REJECT = 2'b10
    } ch_state_e;

    typedef struct packed {
        logic filt;
        logic armed;
    } cs_stat_t;

endpackage

// File: rtl/spi_valdet_ctrl_cs_filter.sv
// One chip-select conditioner: synchroniser, stability filter, armed flag.
// Armed only once a real post-reset sample has shown the select released.
module spi_valdet_ctrl_cs_filter
    import spi_valdet_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 3
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    input  logic     cs_n,
    output cs_stat_t stat
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] primed_q;
    logic                   sync_out;
    logic                   primed;
    logic                   filt;
    logic                   armed_q;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign primed   = primed_q[SYNC_STAGES-1];

    // Sync chain plus a marker that tracks when reset values have drained out.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q   <= '1;
            primed_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], cs_n};
            primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    if (FILT_CYC == 0) begin : g_bypass
        assign filt = sync_out;
    end else begin : g_filt
        localparam int FW = (FILT_CYC < 2) ? 1 : $clog2(FILT_CYC);
        logic [FW-1:0] cnt_q;
        logic          filt_q;

        // Accept a new level only after FILT_CYC identical differing samples.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                cnt_q  <= '0;
                filt_q <= 1'b1;
            end else if (sync_out != filt_q) begin
                if (cnt_q == FW'(FILT_CYC - 1)) begin
                    filt_q <= sync_out;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end

        assign filt = filt_q;
    end

    // Arm once a genuine high sample is seen while the filtered level is high.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_q | (primed & sync_out & filt);
        end
    end

    assign stat = '{filt: filt, armed: armed_q};

endmodule

// File: rtl/spi_valdet_ctrl.sv
// SPI frame-validity detector: per-channel FSMs, fixed-priority grant,
// and the self-timed EE write-busy window.
module spi_valdet_ctrl
    import spi_valdet_ctrl_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 3,
    parameter int PROG_CYCLES = 5000,
    parameter int CNT_W       = 13
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [NCH-1:0]   spi_cs_n,
    input  logic [NCH-1:0]   spi_prog_en,
    input  logic             spi_wbusy_clr,
    output logic [NCH-1:0]   spi_valid,
    output logic [NCH-1:0]   spi_start_pulse,
    output logic [NCH-1:0]   spi_end_pulse,
    output logic [NCH-1:0]   spi_reject_pulse,
    output logic             spi_ee_wbusy,
    output logic [CNT_W-1:0] spi_busy_cnt
);

    logic [NCH-1:0] cs_filt;
    logic [NCH-1:0] armed;
    logic [NCH-1:0] cs_q;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] valid_nx;
    logic [NCH-1:0] start_nx;
    logic [NCH-1:0] end_nx;
    logic [NCH-1:0] rej_nx;
    logic           busy_set;
    logic           taken;
    ch_state_e      state    [NCH];
    ch_state_e      state_nx [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        cs_stat_t st;

        spi_valdet_ctrl_cs_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYC    (FILT_CYC)
        ) u_filt (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .cs_n      (spi_cs_n[g]),
            .stat      (st)
        );

        assign cs_filt[g] = st.filt;
        assign armed[g]   = st.armed;
    end

    // Previous filtered level for edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cs_q <= '1;
        end else begin
            cs_q <= cs_filt;
        end
    end

    assign fall = cs_q & ~cs_filt & armed;
    assign rise = ~cs_q & cs_filt;

    // Next state and pulses; the first accepted fall claims the grant.
    always_comb begin
        taken    = spi_ee_wbusy;
        busy_set = 1'b0;
        valid_nx = '0;
        start_nx = '0;
        end_nx   = '0;
        rej_nx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (state[i] == ST_ACTIVE) taken = 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
            state_nx[i] = state[i];
            unique case (state[i])
                ST_IDLE: begin
                    if (fall[i]) begin
                        if (!taken) begin
                            state_nx[i] = ST_ACTIVE;
                            start_nx[i] = 1'b1;
                            taken       = 1'b1;
                        end else begin
                            state_nx[i] = ST_REJECT;
                            rej_nx[i]   = 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (rise[i]) begin
                        state_nx[i] = ST_IDLE;
                        end_nx[i]   = 1'b1;
                        busy_set    = busy_set | spi_prog_en[i];
                    end
                end
                ST_REJECT: begin
                    if (rise[i]) state_nx[i] = ST_IDLE;
                end
                default: state_nx[i] = ST_IDLE;
            endcase
            valid_nx[i] = (state_nx[i] == ST_ACTIVE);
        end
    end

    // Channel state and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NCH; i++) state[i] <= ST_IDLE;
            spi_valid        <= '0;
            spi_start_pulse  <= '0;
            spi_end_pulse    <= '0;
            spi_reject_pulse <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) state[i] <= state_nx[i];
            spi_valid        <= valid_nx;
            spi_start_pulse  <= start_nx;
            spi_end_pulse    <= end_nx;
            spi_reject_pulse <= rej_nx;
        end
    end

    // Busy window: abort beats load, load beats countdown.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            spi_ee_wbusy <= 1'b0;
            spi_busy_cnt <= '0;
        end else if (spi_wbusy_clr) begin
            spi_ee_wbusy <= 1'b0;
            spi_busy_cnt <= '0;
        end else if (busy_set) begin
            spi_ee_wbusy <= 1'b1;
            spi_busy_cnt <= CNT_W'(PROG_CYCLES - 1);
        end else if (spi_ee_wbusy) begin
            if (spi_busy_cnt == '0) begin
                spi_ee_wbusy <= 1'b0;
            end else begin
                spi_busy_cnt <= spi_busy_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_valdet_ctrl.sv
// Directed bench for spi_valdet_ctrl with a pad-level behavioural model.
module tb_spi_valdet_ctrl;

    localparam int NCH   = 2;
    localparam int FILT  = 3;
    localparam int PROG  = 5000;
    localparam int CNT_W = 13;
    localparam int LAT   = 3;

    logic             clk;
    logic             rst_n;
    logic [NCH-1:0]   cs_n;
    logic [NCH-1:0]   prog_en;
    logic             wclr;
    logic [NCH-1:0]   valid;
    logic [NCH-1:0]   start_p;
    logic [NCH-1:0]   end_p;
    logic [NCH-1:0]   rej_p;
    logic             wbusy;
    logic [CNT_W-1:0] bcnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_on   = 0;

    spi_valdet_ctrl #(
        .NCH         (NCH),
        .SYNC_STAGES (2),
        .FILT_CYC    (FILT),
        .PROG_CYCLES (PROG),
        .CNT_W       (CNT_W)
    ) dut (
        .sys_clk          (clk),
        .sys_rst_n        (rst_n),
        .spi_cs_n         (cs_n),
        .spi_prog_en      (prog_en),
        .spi_wbusy_clr    (wclr),
        .spi_valid        (valid),
        .spi_start_pulse  (start_p),
        .spi_end_pulse    (end_p),
        .spi_reject_pulse (rej_p),
        .spi_ee_wbusy     (wbusy),
        .spi_busy_cnt     (bcnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h",
                     nm, cyc, act, exp);
        end
    endtask

    // Model: filtered edges become channel events LAT edges after the
    // FILT-th identical pad sample; events drive frame ownership and busy.
    typedef struct {
        int t;
        int ch;
        bit rise;
        bit arm;
    } ev_t;

    ev_t          evq[$];
    bit           m_filt [NCH];
    bit           m_arm  [NCH];
    bit           m_runv [NCH];
    int           m_runl [NCH];
    bit           m_act  [NCH];
    int           m_left;
    int           m_now;
    bit [NCH-1:0] e_valid, e_start, e_end, e_rej;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evq.delete();
            for (int i = 0; i < NCH; i++) begin
                m_filt[i] = 1; m_arm[i] = 0; m_runv[i] = 1;
                m_runl[i] = 0; m_act[i] = 0;
            end
            m_left = 0; m_now = 0;
            e_valid = '0; e_start = '0; e_end = '0; e_rej = '0;
        end else begin
            bit busy_now;
            bit owned;
            bit setb;
            m_now++;
            e_start = '0; e_end = '0; e_rej = '0;
            busy_now = (m_left > 0);
            owned = 0;
            setb = 0;
            for (int i = 0; i < NCH; i++) if (m_act[i]) owned = 1;
            for (int i = 0; i < NCH; i++) begin
                foreach (evq[k]) begin
                    if (evq[k].t == m_now && evq[k].ch == i) begin
                        if (!evq[k].rise) begin
                            if (evq[k].arm) begin
                                if (!busy_now && !owned) begin
                                    m_act[i] = 1; e_start[i] = 1; owned = 1;
                                end else begin
                                    e_rej[i] = 1;
                                end
                            end
                        end else if (m_act[i]) begin
                            m_act[i] = 0; e_end[i] = 1;
                            if (prog_en[i]) setb = 1;
                        end
                    end
                end
            end
            for (int k = evq.size() - 1; k >= 0; k--)
                if (evq[k].t <= m_now) evq.delete(k);
            if (wclr) m_left = 0;
            else if (setb) m_left = PROG;
            else if (m_left > 0) m_left--;
            for (int i = 0; i < NCH; i++) begin
                bit v;
                v = cs_n[i];
                if (v == m_runv[i]) m_runl[i]++;
                else begin m_runv[i] = v; m_runl[i] = 1; end
                if (v && m_filt[i]) m_arm[i] = 1;
                if (m_runl[i] == FILT && m_runv[i] != m_filt[i]) begin
                    m_filt[i] = m_runv[i];
                    evq.push_back('{m_now + LAT, i, m_runv[i], m_arm[i]});
                end
                e_valid[i] = m_act[i];
            end
        end
    end

    int n_start [NCH];
    int n_end   [NCH];
    int n_rej   [NCH];
    int l_start [NCH];
    int l_end   [NCH];
    int l_rej   [NCH];
    int v_hi    [NCH];
    int busy_hi = 0;
    int first_cnt = -1;
    bit wbusy_d = 0;

    // Per-cycle comparison against the model plus event bookkeeping.
    always @(negedge clk) begin
        if (chk_on) begin
            int exp_cnt;
            exp_cnt = (m_left > 0) ? m_left - 1 : 0;
            chk("valid", 32'(valid), 32'(e_valid));
            chk("start_pulse", 32'(start_p), 32'(e_start));
            chk("end_pulse", 32'(end_p), 32'(e_end));
            chk("reject_pulse", 32'(rej_p), 32'(e_rej));
            chk("wbusy", 32'(wbusy), 32'(m_left > 0));
            chk("busy_cnt", 32'(bcnt), 32'(exp_cnt));
            for (int i = 0; i < NCH; i++) begin
                if (start_p[i]) begin n_start[i]++; l_start[i] = cyc; end
                if (end_p[i])   begin n_end[i]++;   l_end[i]   = cyc; end
                if (rej_p[i])   begin n_rej[i]++;   l_rej[i]   = cyc; end
                if (valid[i]) v_hi[i]++;
            end
            if (wbusy) busy_hi++;
            if (wbusy && !wbusy_d) first_cnt = int'(bcnt);
            wbusy_d = wbusy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int c0, c1, s0, e0, r1, v0, b0, k;
        for (int i = 0; i < NCH; i++) begin
            n_start[i] = 0; n_end[i] = 0; n_rej[i] = 0;
            l_start[i] = 0; l_end[i] = 0; l_rej[i] = 0; v_hi[i] = 0;
        end
        rst_n = 1; cs_n = '1; prog_en = '0; wclr = 0;
        #3 rst_n = 0;
        chk_on = 1;
        tick(3);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_wbusy", 32'(wbusy), 0);
        chk("rst_cnt", 32'(bcnt), 0);
        rst_n = 1;
        tick(8);

        // Plain frame on ch0.
        c0 = cyc; v0 = v_hi[0]; b0 = busy_hi;
        cs_n[0] = 0; tick(20);
        c1 = cyc;
        cs_n[0] = 1; tick(10);
        chk("t1_start_lat", l_start[0], c0 + 6);
        chk("t1_end_lat", l_end[0], c1 + 6);
        chk("t1_valid_len", v_hi[0] - v0, 20);
        chk("t1_no_busy", busy_hi - b0, 0);

        // EE write frame sets a 5000-cycle busy window.
        b0 = busy_hi;
        cs_n[0] = 0; tick(10);
        cs_n[0] = 1; prog_en[0] = 1; tick(8);
        prog_en[0] = 0;
        tick(5010);
        chk("t2_busy_len", busy_hi - b0, 5000);
        chk("t2_first_cnt", first_cnt, 4999);
        chk("t2_busy_done", 32'(wbusy), 0);

        // ch1 fall during busy is rejected; then abort busy at count 100.
        cs_n[0] = 0; tick(10);
        cs_n[0] = 1; prog_en[0] = 1; tick(8);
        prog_en[0] = 0;
        s0 = n_start[1]; r1 = n_rej[1]; v0 = v_hi[1];
        cs_n[1] = 0; tick(10);
        cs_n[1] = 1; tick(10);
        chk("t3_rej1", n_rej[1] - r1, 1);
        chk("t3_nostart1", n_start[1] - s0, 0);
        chk("t3_novalid1", v_hi[1] - v0, 0);
        k = 0;
        while (bcnt != 100 && k < 6000) begin tick(1); k++; end
        chk("t6_wait_cnt100", 32'(k < 6000), 1);
        wclr = 1; tick(1);
        wclr = 0;
        chk("t6_clr_wbusy", 32'(wbusy), 0);
        chk("t6_clr_cnt", 32'(bcnt), 0);
        tick(5);

        // Simultaneous falls: ch0 wins, ch1 rejected in the same cycle.
        c0 = cyc; s0 = n_start[1];
        cs_n = 2'b00; tick(10);
        chk("t4_start0", l_start[0], c0 + 6);
        chk("t4_rej1_same", l_rej[1], c0 + 6);
        cs_n[0] = 1; tick(12);
        chk("t4_ch1_held", n_start[1] - s0, 0);
        cs_n[1] = 1; tick(10);
        cs_n[1] = 0; tick(10);
        chk("t4_ch1_again", n_start[1] - s0, 1);
        cs_n[1] = 1; tick(10);

        // Two-cycle glitches vanish; a three-cycle low is a frame.
        s0 = n_start[0]; e0 = n_end[0]; r1 = n_rej[0];
        cs_n[0] = 0; tick(2); cs_n[0] = 1; tick(5);
        cs_n[0] = 0; tick(2); cs_n[0] = 1; tick(10);
        chk("t5_glitch_start", n_start[0] - s0, 0);
        chk("t5_glitch_rej", n_rej[0] - r1, 0);
        cs_n[0] = 0; tick(3); cs_n[0] = 1; tick(12);
        chk("t5_short_start", n_start[0] - s0, 1);
        chk("t5_short_end", n_end[0] - e0, 1);

        // cs_n[0] low across reset release produces nothing.
        s0 = n_start[0]; e0 = n_end[0]; r1 = n_rej[0];
        rst_n = 0; cs_n[0] = 0; tick(3);
        rst_n = 1; tick(15);
        cs_n[0] = 1; tick(15);
        chk("t6_held_start", n_start[0] - s0, 0);
        chk("t6_held_rej", n_rej[0] - r1, 0);
        chk("t6_held_end", n_end[0] - e0, 0);
        cs_n[0] = 0; tick(10);
        chk("t6_rearmed", n_start[0] - s0, 1);
        cs_n[0] = 1; tick(10);

        // Reset mid-frame: valid drops at once, no end pulse, no busy.
        e0 = n_end[0]; b0 = busy_hi;
        cs_n[0] = 0; prog_en[0] = 1; tick(10);
        chk("t6_mid_valid", 32'(valid[0]), 1);
        rst_n = 0; #1;
        chk("t6_async_valid", 32'(valid[0]), 0);
        tick(2);
        cs_n[0] = 1; tick(2);
        rst_n = 1; tick(15);
        prog_en[0] = 0;
        chk("t6_mid_noend", n_end[0] - e0, 0);
        chk("t6_mid_nobusy", busy_hi - b0, 0);

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
